// File: rtl/bna_quant_pkg.sv
// Shared constants and types for the activation output quantizer.
package bna_quant_pkg;

    // Exponent bias of the accumulator floating format.
    localparam int unsigned EXP_BIAS = 127;

    // int8 saturation limits.
    localparam logic signed [7:0] INT8_MAX = 8'sh7F;
    localparam logic signed [7:0] INT8_MIN = 8'sh80;

    // Drain job controller states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fp_to_int8_lane.sv
// Single-lane converter: accumulator (exp, signed 24-bit mantissa) to
// saturated int8 with optional ReLU. One-cycle registered latency.
module fp_to_int8_lane #(
    parameter int unsigned EXP_BIAS = bna_quant_pkg::EXP_BIAS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [7:0]  i_exp,
    input  logic [23:0] i_mant,
    input  logic [4:0]  i_frac_bits,
    input  logic        i_relu_en,
    output logic        o_valid,
    output logic [7:0]  o_q
);
    import bna_quant_pkg::*;

    logic [9:0]         s;
    logic [9:0]         s_neg;
    logic [4:0]         rsh;
    logic signed [31:0] mant_ext;
    logic signed [31:0] shifted;
    logic               sat_big;
    logic [7:0]         q_next;

    // Scale by 2^s, then ReLU, then clamp into int8.
    always_comb begin
        s        = 10'(i_exp) + 10'(i_frac_bits) - 10'(EXP_BIAS);
        s_neg    = '0 - s;
        rsh      = (s_neg > 10'd31) ? 5'd31 : s_neg[4:0];
        mant_ext = 32'($signed(i_mant));
        sat_big  = 1'b0;
        shifted  = mant_ext;
        if (!s[9]) begin
            // Any shift of 8 or more pushes a nonzero mantissa out of int8.
            sat_big = (s[8:3] != '0) && (i_mant != '0);
            shifted = mant_ext <<< s[2:0];
        end else begin
            shifted = mant_ext >>> rsh;
        end
        if (i_relu_en && i_mant[23]) begin
            q_next = '0;
        end else if (sat_big) begin
            q_next = i_mant[23] ? INT8_MIN : INT8_MAX;
        end else if (shifted > 32'sd127) begin
            q_next = INT8_MAX;
        end else if (shifted < -32'sd128) begin
            q_next = INT8_MIN;
        end else begin
            q_next = shifted[7:0];
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_q     <= '0;
        end else begin
            o_valid <= i_valid;
            o_q     <= q_next;
        end
    end

endmodule

// File: rtl/output_quantizer_dual.sv
// Drains the dual-lane accumulator FIFO, quantizes each pair to int8 and
// packs four pairs per 64-bit word into the activation output buffer.
module output_quantizer_dual #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned EXP_BIAS   = bna_quant_pkg::EXP_BIAS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [CNT_WIDTH-1:0]  i_num_pairs,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [4:0]            i_frac_bits,
    input  logic                  i_relu_en,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [31:0]           i_accum_data_0,
    input  logic [31:0]           i_accum_data_1,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [63:0]           o_wr_data,
    output logic                  o_wr_last,
    output logic                  o_busy,
    output logic                  o_done
);
    import bna_quant_pkg::*;

    state_t                state, next_state;
    logic [CNT_WIDTH-1:0]  num_q, issued_q, packed_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [4:0]            frac_q;
    logic                  relu_q;
    logic                  rd_q;
    logic [1:0]            slot_q;
    logic [63:0]           pack_q, pack_word;
    logic                  v0, v1, lane_valid;
    logic [7:0]            q0, q1;
    logic                  final_pair, pack_done;

    fp_to_int8_lane #(.EXP_BIAS(EXP_BIAS)) u_lane0 (
        .clk(clk), .rst_n(rst_n), .i_valid(rd_q),
        .i_exp(i_accum_data_0[31:24]), .i_mant(i_accum_data_0[23:0]),
        .i_frac_bits(frac_q), .i_relu_en(relu_q), .o_valid(v0), .o_q(q0)
    );

    fp_to_int8_lane #(.EXP_BIAS(EXP_BIAS)) u_lane1 (
        .clk(clk), .rst_n(rst_n), .i_valid(rd_q),
        .i_exp(i_accum_data_1[31:24]), .i_mant(i_accum_data_1[23:0]),
        .i_frac_bits(frac_q), .i_relu_en(relu_q), .o_valid(v1), .o_q(q1)
    );

    assign lane_valid = v0 & v1;
    // Busy covers the final write cycle, which coincides with DONE.
    assign o_busy = (state == ST_RUN) || (state == ST_FLUSH) || ((state == ST_DONE) && o_wr_en);

    // Merge the incoming lane pair into the current slot of the pack word.
    always_comb begin
        final_pair = (packed_q + CNT_WIDTH'(1)) == num_q;
        pack_word  = pack_q;
        pack_word[{slot_q, 4'b1000} +: 8] = q0;
        pack_word[{slot_q, 4'b0000} +: 8] = q1;
        pack_done  = lane_valid ? final_pair : (packed_q == num_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state and FIFO pop decode.
    always_comb begin
        next_state   = state;
        o_fifo_rd_en = 1'b0;
        case (state)
            ST_IDLE: if (i_start) next_state = (i_num_pairs == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (issued_q == num_q) next_state = ST_FLUSH;
                else                   o_fifo_rd_en = !i_fifo_empty;
            end
            // The final pair is always packed while in FLUSH, and that pack
            // emits the last (possibly partial) word itself.
            ST_FLUSH: if (pack_done) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Job registers, counters, packing and write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_q     <= '0;
            issued_q  <= '0;
            packed_q  <= '0;
            addr_q    <= '0;
            frac_q    <= '0;
            relu_q    <= 1'b0;
            rd_q      <= 1'b0;
            slot_q    <= '0;
            pack_q    <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_wr_last <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            rd_q      <= o_fifo_rd_en;
            o_wr_en   <= 1'b0;
            o_wr_last <= 1'b0;
            o_done    <= (state == ST_DONE);
            if (state == ST_IDLE && i_start) begin
                num_q    <= i_num_pairs;
                addr_q   <= i_base_addr;
                frac_q   <= i_frac_bits;
                relu_q   <= i_relu_en;
                issued_q <= '0;
                packed_q <= '0;
                slot_q   <= '0;
                pack_q   <= '0;
            end
            if (o_fifo_rd_en) issued_q <= issued_q + CNT_WIDTH'(1);
            if (lane_valid) begin
                packed_q <= packed_q + CNT_WIDTH'(1);
                if (slot_q == 2'd3 || final_pair) begin
                    o_wr_en   <= 1'b1;
                    o_wr_data <= pack_word;
                    o_wr_addr <= addr_q;
                    o_wr_last <= final_pair;
                    addr_q    <= addr_q + ADDR_WIDTH'(1);
                    pack_q    <= '0;
                    slot_q    <= '0;
                end else begin
                    pack_q <= pack_word;
                    slot_q <= slot_q + 2'd1;
                end
            end
        end
    end

endmodule
